mux_scan_ctrl: RTL and testbench

Sequencer for an 8:1 data selector (74151-class mux) in the TTL CPU datapath. It drives the mux select lines and waits a programmable settle time after each select change, because select-to-output delay is up to 43 ns. It then samples the mux output and assembles the eight channel bits into a byte, or samples a single chosen channel. The result goes to the consumer over a valid/ready handshake.

---
 rtl/mux_scan_ctrl_if.sv | 37 +++
 rtl/mux_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl_if
// Description : Signal bundle between the 8:1 mux scan sequencer, its
//               requester, the external 74151-class mux and the result
//               consumer.
//   start/single/chan : conversion request (sampled in IDLE)
//   sel / mux_out     : mux select lines and mux output
//   data/valid/ready  : result byte with valid/ready handshake
//   busy              : conversion in progress until handshake completes
//   slave modport  : the sequencer side
//   master modport : the requester / mux / consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if;
  logic       start;
  logic       single;
  logic [2:0] chan;
  logic [2:0] sel;
  logic       mux_out;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;

  modport slave (
    input  start, single, chan, mux_out, ready,
    output sel, data, valid, busy
  );

  modport master (
    output start, single, chan, mux_out, ready,
    input  sel, data, valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Sequencer for an external 8:1 data selector. Steps the
//               select lines, waits SETTLE cycles after every select change,
//               samples the mux output, and either assembles all eight
//               channels into a byte (scan) or returns one channel in bit 0
//               (single). Result is offered on a valid/ready handshake.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous active-high reset
//               bus   - mux_scan_ctrl_if.slave (request, mux, result)
// Parameters  : SETTLE - wait cycles after a select change (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic           clk,
  input  logic           reset,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Counter reload: SETTLE-1 down to 0 gives SETTLE settle cycles.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  // Bits 0..6 of the scan; bit 7 comes straight from the final sample.
  logic [6:0] acc, acc_nxt;
  logic       mode, mode_nxt;      // 1 = single-channel conversion
  logic [2:0] sel_q, sel_nxt;
  logic [7:0] data_q, data_nxt;
  logic       valid_q, valid_nxt;
  logic       busy_q, busy_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      acc     <= 7'd0;
      mode    <= 1'b0;
      sel_q   <= 3'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      mode    <= mode_nxt;
      sel_q   <= sel_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    mode_nxt  = mode;
    sel_nxt   = sel_q;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    busy_nxt  = busy_q;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          // In single mode the chosen channel lives in sel for the whole
          // conversion, so no separate channel register is needed.
          mode_nxt  = bus.single;
          sel_nxt   = bus.single ? bus.chan : 3'd0;
          cnt_nxt   = CNT_LOAD;
          acc_nxt   = 7'd0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (mode) begin
          data_nxt  = {7'd0, bus.mux_out};
          valid_nxt = 1'b1;
          state_nxt = ST_HOLD;
        end else if (sel_q != 3'd7) begin
          acc_nxt[sel_q] = bus.mux_out;
          sel_nxt        = sel_q + 3'd1;
          cnt_nxt        = CNT_LOAD;
          state_nxt      = ST_SETTLE;
        end else begin
          data_nxt  = {bus.mux_out, acc};
          valid_nxt = 1'b1;
          state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (bus.ready) begin
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Testbench for mux_scan_ctrl. Three sequencers with SETTLE of
//               2, 1 and 15, each driving its own behavioural 8:1 mux with a
//               43 ns select-to-output delay. Expected selects, latencies and
//               result bytes come from the conversion rules directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  localparam int N_DUT = 3;

  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  logic       start_a  [N_DUT];
  logic       single_a [N_DUT];
  logic [2:0] chan_a   [N_DUT];
  logic       ready_a  [N_DUT];
  logic [7:0] in_a     [N_DUT];
  logic [2:0] sel_a    [N_DUT];
  logic [7:0] data_a   [N_DUT];
  logic       valid_a  [N_DUT];
  logic       busy_a   [N_DUT];
  logic [7:0] last_data[N_DUT];

  int checks   = 0;
  int failures = 0;

  function automatic int settle_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mux_scan_ctrl_if bus();
    logic mux_d;

    assign bus.start   = start_a[g];
    assign bus.single  = single_a[g];
    assign bus.chan    = chan_a[g];
    assign bus.ready   = ready_a[g];
    assign bus.mux_out = mux_d;
    assign sel_a[g]    = bus.sel;
    assign data_a[g]   = bus.data;
    assign valid_a[g]  = bus.valid;
    assign busy_a[g]   = bus.busy;

    // 74151 model: output follows In[S] after 43 ns.
    always @(in_a[g], bus.sel) mux_d <= #43 in_a[g][bus.sel];

    mux_scan_ctrl #(.SETTLE(settle_of(g))) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_all();
    for (int g = 0; g < N_DUT; g++) begin
      check_val("rst_sel",   sel_a[g],   0);
      check_val("rst_data",  data_a[g],  0);
      check_val("rst_valid", valid_a[g], 0);
      check_val("rst_busy",  busy_a[g],  0);
      last_data[g] = 8'd0;
    end
  endtask

  // One complete conversion on instance g. Entered and left in IDLE,
  // #1 after a rising edge.
  task automatic run_conv(input int g, input bit sg, input bit [2:0] ch, input bit [7:0] pat,
                          input bit glitch, input int hold, input bit rdy_early);
    int         s;
    int         lat;
    logic [7:0] exp_data;
    logic [2:0] exp_sel;
    logic [2:0] fin_sel;
    s        = settle_of(g);
    lat      = sg ? (s + 1) : 8 * (s + 1);
    exp_data = sg ? {7'd0, pat[ch]} : pat;
    fin_sel  = sg ? ch : 3'd7;

    start_a[g]  = 1'b1;
    single_a[g] = sg;
    chan_a[g]   = ch;
    ready_a[g]  = rdy_early;
    in_a[g]     = glitch ? 8'($urandom) : pat;
    tick();
    start_a[g]  = 1'b0;
    single_a[g] = 1'($urandom);
    chan_a[g]   = 3'($urandom);

    for (int j = 1; j <= lat; j++) begin
      exp_sel = sg ? ch : 3'((j - 1) / (s + 1));
      check_val("sel_step",   sel_a[g],   exp_sel);
      check_val("valid_early", valid_a[g], 0);
      check_val("busy_run",   busy_a[g],  1);
      check_val("data_held",  data_a[g],  last_data[g]);
      if (glitch) in_a[g] = ((j % (s + 1)) == 0) ? pat : 8'($urandom);
      start_a[g] = 1'($urandom);
      tick();
    end
    start_a[g] = 1'b0;

    check_val("valid_rise", valid_a[g], 1);
    check_val("data_res",   data_a[g],  exp_data);
    check_val("busy_res",   busy_a[g],  1);
    check_val("sel_final",  sel_a[g],   fin_sel);
    last_data[g] = exp_data;

    if (!rdy_early) begin
      for (int k = 0; k < hold; k++) begin
        start_a[g] = 1'($urandom);
        in_a[g]    = 8'($urandom);
        tick();
        check_val("hold_valid", valid_a[g], 1);
        check_val("hold_data",  data_a[g],  exp_data);
        check_val("hold_busy",  busy_a[g],  1);
        check_val("hold_sel",   sel_a[g],   fin_sel);
      end
    end

    // Handshake edge with start also high: start must not be taken here.
    ready_a[g] = 1'b1;
    start_a[g] = 1'b1;
    tick();
    check_val("xfer_valid", valid_a[g], 0);
    check_val("xfer_busy",  busy_a[g],  0);
    check_val("xfer_data",  data_a[g],  exp_data);
    start_a[g] = 1'b0;
    ready_a[g] = 1'($urandom);
    tick();
    check_val("idle_valid", valid_a[g], 0);
    check_val("idle_busy",  busy_a[g],  0);
    check_val("idle_data",  data_a[g],  exp_data);
    ready_a[g] = 1'b0;
  endtask

  // Start a scan, reset when sel reaches channel 4.
  task automatic run_abort(input int g, input bit [7:0] pat);
    int s;
    s = settle_of(g);
    start_a[g]  = 1'b1;
    single_a[g] = 1'b0;
    chan_a[g]   = 3'd0;
    in_a[g]     = pat;
    tick();
    start_a[g] = 1'b0;
    for (int j = 1; j <= 4 * (s + 1); j++) tick();
    check_val("abort_sel4", sel_a[g],  4);
    check_val("abort_busy", busy_a[g], 1);
    reset = 1'b1;
    tick();
    check_reset_all();
    reset = 1'b0;
    tick();
    check_val("abort_idle", busy_a[g], 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int g = 0; g < N_DUT; g++) begin
      start_a[g]   = 1'b1;
      single_a[g]  = 1'b0;
      chan_a[g]    = 3'd0;
      ready_a[g]   = 1'b0;
      in_a[g]      = 8'd0;
      last_data[g] = 8'd0;
    end
    tick();
    tick();
    check_reset_all();
    reset = 1'b0;
    for (int g = 0; g < N_DUT; g++) start_a[g] = 1'b0;
    tick();
    for (int g = 0; g < N_DUT; g++) check_val("post_rst_idle", busy_a[g], 0);

    run_conv(0, 1'b0, 3'd0, 8'hA5, 1'b0, 0,  1'b0);
    run_conv(0, 1'b1, 3'd6, 8'h40, 1'b0, 0,  1'b0);
    run_conv(0, 1'b1, 3'd5, 8'h40, 1'b0, 0,  1'b0);
    run_conv(0, 1'b0, 3'd0, 8'h5A, 1'b0, 10, 1'b0);
    run_abort(0, 8'hA5);
    run_conv(0, 1'b0, 3'd0, 8'h3C, 1'b0, 0,  1'b0);
    run_conv(0, 1'b0, 3'd0, 8'h96, 1'b1, 0,  1'b0);
    run_conv(1, 1'b0, 3'd0, 8'h96, 1'b1, 0,  1'b0);
    run_conv(2, 1'b0, 3'd0, 8'h96, 1'b1, 0,  1'b0);
    run_conv(0, 1'b0, 3'd0, 8'hC3, 1'b0, 0,  1'b1);
    run_conv(1, 1'b1, 3'd7, 8'h80, 1'b1, 2,  1'b0);

    for (int i = 0; i < 40; i++) begin
      run_conv(int'($urandom_range(0, 2)), 1'($urandom), 3'($urandom), 8'($urandom),
               1'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
